// File: rtl/pa_f_spsram_256x4_ctrl.sv
// rtl/pa_f_spsram_256x4_ctrl.sv - read/masked-write arbiter, 1-entry write buffer and clear sweep for the 256x4 SP-SRAM
// Define PA_F_SRAM_INIT_EN to build the power-on / requested clear sweep (INIT state).
module pa_f_spsram_256x4_ctrl #(
  parameter int                IDX_W    = 8,
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              rd_vld,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_rdy,
  output logic              rdata_vld,
  output logic [DATA_W-1:0] rdata,
  input  logic              wr_vld,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_mask,
  output logic              wr_rdy,
  output logic [IDX_W-1:0]  sram_a,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  logic              buf_vld;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] buf_data;
  logic [DATA_W-1:0] buf_mask;
  logic [DATA_W-1:0] fwd_mask;
  logic [DATA_W-1:0] fwd_data;
  logic              in_init;
  logic              init_go;
  logic              gate;
  logic              rd_fire;
  logic              wr_fire;
  logic              drain;
  logic [IDX_W-1:0]  sweep_idx;

`ifdef PA_F_SRAM_INIT_EN
  typedef enum logic {IDLE, INIT} state_t;
  localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == '1) state_nxt = IDLE;
      end
      default: begin
        if (init_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  assign in_init   = (state == INIT);
  assign init_go   = (state == IDLE) && init_req;
  assign sweep_idx = cnt;
`else
  logic [DATA_W:0] unused_init;
  assign unused_init = {init_req, INIT_VAL};
  assign in_init     = 1'b0;
  assign init_go     = 1'b0;
  assign sweep_idx   = '0;
`endif

  // A pending write blocks new reads so the buffer is guaranteed to drain.
  assign gate      = in_init || init_go;
  assign rd_rdy    = !gate && !(buf_vld && wr_vld);
  assign rd_fire   = rd_vld && rd_rdy;
  assign drain     = !gate && buf_vld && !rd_fire;
  assign wr_rdy    = !gate && (!buf_vld || drain);
  assign wr_fire   = wr_vld && wr_rdy;
  assign init_busy = in_init;

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (in_init) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = sweep_idx;
      sram_d    = INIT_VAL;
    end else if (rd_fire) begin
      sram_cen = 1'b0;
      sram_a   = rd_idx;
    end else if (drain) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~buf_mask;
      sram_a    = buf_idx;
      sram_d    = buf_data;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      buf_vld   <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
      buf_mask  <= '0;
      rdata_vld <= 1'b0;
      fwd_mask  <= '0;
      fwd_data  <= '0;
    end else begin
      rdata_vld <= rd_fire;
      if (rd_fire) begin
        if (buf_vld && (buf_idx == rd_idx)) begin
          fwd_mask <= buf_mask;
          fwd_data <= buf_data;
        end else begin
          fwd_mask <= '0;
        end
      end
      // The sweep overwrites everything, so a buffered write is simply dropped.
      if (init_go) begin
        buf_vld <= 1'b0;
      end else if (wr_fire) begin
        buf_vld  <= 1'b1;
        buf_idx  <= wr_idx;
        buf_data <= wr_data;
        buf_mask <= wr_mask;
      end else if (drain) begin
        buf_vld <= 1'b0;
      end
    end
  end

  assign rdata = (sram_q & ~fwd_mask) | (fwd_data & fwd_mask);

endmodule
